// File: rtl/led_pattern_seq.sv
// led_pattern_seq: LED blink-mode sequencer with a button-adjustable period.
// Three active-low keys are synchronised, debounced and edge-detected. The
// resulting presses queue a period request that is applied at the next tick.
// Optional feature: define LED_CHASE_EN to add mode 3, a walking green bit.
module led_pattern_seq #(
  parameter int WIDTH      = 8,
  parameter int STEP_TICKS = 12500000,
  parameter int DEF_STEPS  = 2,
  parameter int MIN_STEPS  = 1,
  parameter int MAX_STEPS  = 8,
  parameter int BLINKS     = 3,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                           CLOCK_50,
  input  logic                           RESET,
  input  logic [2:0]                     KEY,
  output logic [WIDTH-1:0]               LEDG,
  output logic [WIDTH-1:0]               LEDR,
  output logic [1:0]                     MODE,
  output logic [$clog2(MAX_STEPS+1)-1:0] STEPS
);

  localparam int PHASES = 2 * BLINKS;
  localparam int PW     = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int DW     = $clog2(DEB_CYCLES + 1);
  localparam int SW     = $clog2(MAX_STEPS + 1);

`ifdef LED_CHASE_EN
  typedef enum logic [1:0] {MODE_GREEN = 2'd0, MODE_RED = 2'd1, MODE_BOTH = 2'd2,
                            MODE_CHASE = 2'd3} mode_e;
  localparam mode_e LAST_MODE = MODE_CHASE;
`else
  typedef enum logic [1:0] {MODE_GREEN = 2'd0, MODE_RED = 2'd1, MODE_BOTH = 2'd2} mode_e;
  localparam mode_e LAST_MODE = MODE_BOTH;
`endif

  typedef enum logic [1:0] {REQ_NONE, REQ_SLOWER, REQ_FASTER, REQ_DEFAULT} req_e;

  logic [2:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]          deb_q, deb_d, press_q, press_d;
  logic [2:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  req_e                pend_q, pend_d;
  logic [31:0]         cnt_q, cnt_d, period;
  logic [SW-1:0]       steps_q, steps_d;
  logic [PW-1:0]       phase_q, phase_d;
  mode_e               mode_q, mode_d;
  logic [WIDTH-1:0]    ledg_q, ledg_d, ledr_q, ledr_d, blink;
  logic                tick;

  // Key path: synchronise, accept a level after DEB_CYCLES of disagreement, flag 1->0.
  always_comb begin
    sync1_d = KEY;
    sync2_d = sync1_q;
    for (int k = 0; k < 3; k++) begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      deb_d[k]     = deb_q[k];
      deb_cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (deb_cnt_q[k] == DW'(DEB_CYCLES - 1)) deb_d[k] = sync2_q[k];
        else                                     deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
      end
    end
    press_d = deb_q & ~deb_d;
  end

  // Period counter, request application and LED pattern generation at each tick.
  always_comb begin
    period  = 32'(steps_q) * 32'(STEP_TICKS);
    tick    = (cnt_q == period - 32'd1);
    cnt_d   = tick ? 32'd0 : cnt_q + 32'd1;
    pend_d  = pend_q;
    steps_d = steps_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    ledg_d  = ledg_q;
    ledr_d  = ledr_q;
    blink   = phase_q[0] ? '0 : '1;
    if (tick) begin
      pend_d = REQ_NONE;
      case (pend_q)
        REQ_SLOWER:  if (steps_q < SW'(MAX_STEPS)) steps_d = steps_q + 1'b1;
        REQ_FASTER:  if (steps_q > SW'(MIN_STEPS)) steps_d = steps_q - 1'b1;
        REQ_DEFAULT: steps_d = SW'(DEF_STEPS);
        default:     ;
      endcase
      case (mode_q)
        MODE_GREEN: begin ledg_d = blink; ledr_d = '0;    end
        MODE_RED:   begin ledg_d = '0;    ledr_d = blink; end
        MODE_BOTH:  begin ledg_d = blink; ledr_d = blink; end
`ifdef LED_CHASE_EN
        MODE_CHASE: begin ledg_d = WIDTH'(1) << (int'(phase_q) % WIDTH); ledr_d = '0; end
`endif
        default:    begin ledg_d = '0;    ledr_d = '0;    end
      endcase
      if (phase_q == PW'(PHASES - 1)) begin
        phase_d = '0;
        mode_d  = (mode_q == LAST_MODE) ? MODE_GREEN : mode_e'(mode_q + 2'd1);
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
    // A press in the tick cycle overrides the clear, so it waits for the next tick.
    if      (press_q[0]) pend_d = REQ_SLOWER;
    else if (press_q[1]) pend_d = REQ_FASTER;
    else if (press_q[2]) pend_d = REQ_DEFAULT;
  end

  // State register with synchronous reset; all outputs come straight from flops.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (RESET) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      deb_q     <= '1;
      deb_cnt_q <= '0;
      press_q   <= '0;
      pend_q    <= REQ_NONE;
      cnt_q     <= '0;
      steps_q   <= SW'(DEF_STEPS);
      phase_q   <= '0;
      mode_q    <= MODE_GREEN;
      ledg_q    <= '0;
      ledr_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      steps_q   <= steps_d;
      phase_q   <= phase_d;
      mode_q    <= mode_d;
      ledg_q    <= ledg_d;
      ledr_q    <= ledr_d;
    end
  end

  assign LEDG  = ledg_q;
  assign LEDR  = ledr_q;
  assign MODE  = mode_q;
  assign STEPS = steps_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Testbench for led_pattern_seq. The reference model tracks tick count and
// elapsed cycles and derives mode/phase arithmetically from the tick count.
module tb_led_pattern_seq;

  localparam int WIDTH = 8;
  localparam int ST    = 4;
  localparam int DEF   = 2;
  localparam int MINS  = 1;
  localparam int MAXS  = 4;
  localparam int BL    = 3;
  localparam int DEB   = 3;
  localparam int PH    = 2 * BL;
`ifdef LED_CHASE_EN
  localparam int NMODES = 4;
`else
  localparam int NMODES = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key = 3'b111;
  logic [7:0] ledg, ledr;
  logic [1:0] mode;
  logic [2:0] steps;

  always #5 clk = ~clk;

  led_pattern_seq #(
    .WIDTH(WIDTH), .STEP_TICKS(ST), .DEF_STEPS(DEF), .MIN_STEPS(MINS),
    .MAX_STEPS(MAXS), .BLINKS(BL), .DEB_CYCLES(DEB)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .KEY(key),
    .LEDG(ledg), .LEDR(ledr), .MODE(mode), .STEPS(steps)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  bit       raw_h [3][2];     // [0] = key sampled last edge, [1] = two edges ago
  bit       syn_h [3][DEB];   // synchronised samples, newest at index 0
  bit       m_deb [3];
  bit       m_evt [3];
  int       m_pend;           // 0 none, 1 slower, 2 faster, 3 default
  int       m_steps, m_elapsed, m_nticks;
  logic [7:0] m_ledg, m_ledr;
  bit       m_tick;

  function automatic logic [20:0] exp_vec();
    return {m_ledg, m_ledr, 2'((m_nticks / PH) % NMODES), 3'(m_steps)};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {ledg, ledr, mode, steps};
  endfunction

  task automatic model_edge();
    bit s2, nd, all_diff;
    int p, md;
    logic [7:0] on;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        raw_h[k][0] = 1'b1; raw_h[k][1] = 1'b1;
        for (int i = 0; i < DEB; i++) syn_h[k][i] = 1'b1;
        m_deb[k] = 1'b1; m_evt[k] = 1'b0;
      end
      m_pend = 0; m_steps = DEF; m_elapsed = 0; m_nticks = 0;
      m_ledg = '0; m_ledr = '0; m_tick = 1'b0;
      return;
    end
    m_tick = (m_elapsed == m_steps * ST - 1);
    if (m_tick) begin
      case (m_pend)
        1: m_steps = (m_steps + 1 > MAXS) ? MAXS : m_steps + 1;
        2: m_steps = (m_steps - 1 < MINS) ? MINS : m_steps - 1;
        3: m_steps = DEF;
        default: ;
      endcase
      p  = m_nticks % PH;
      md = (m_nticks / PH) % NMODES;
      on = (p % 2 == 0) ? 8'hFF : 8'h00;
      case (md)
        0: begin m_ledg = on;    m_ledr = 8'h00; end
        1: begin m_ledg = 8'h00; m_ledr = on;    end
        2: begin m_ledg = on;    m_ledr = on;    end
        default: begin m_ledg = 8'(1 << (p % WIDTH)); m_ledr = 8'h00; end
      endcase
      m_nticks++;
      m_elapsed = 0;
      m_pend = 0;
    end else begin
      m_elapsed++;
    end
    if      (m_evt[0]) m_pend = 1;
    else if (m_evt[1]) m_pend = 2;
    else if (m_evt[2]) m_pend = 3;
    for (int k = 0; k < 3; k++) begin
      s2 = raw_h[k][1];
      for (int i = DEB - 1; i > 0; i--) syn_h[k][i] = syn_h[k][i-1];
      syn_h[k][0] = s2;
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (syn_h[k][i] == m_deb[k]) all_diff = 1'b0;
      nd = all_diff ? s2 : m_deb[k];
      m_evt[k] = m_deb[k] & ~nd;
      m_deb[k] = nd;
      raw_h[k][1] = raw_h[k][0];
      raw_h[k][0] = key[k];
    end
  endtask

  // One clock: advance the model with the inputs the DUT is about to sample.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reset();
    key = 3'b111;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic press(input int k, input int len);
    key[k] = 1'b0;
    repeat (len) cycle();
    key[k] = 1'b1;
    repeat (8) cycle();
  endtask

  // Waits for the next model tick; cyc = cycles waited, or -1 if the budget ran out.
  task automatic wait_tick(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      cycle();
      if (m_tick) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    n_chk++;
    if (dut_vec() !== {8'h00, 8'h00, 2'd0, 3'd2}) begin
      n_err++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), {8'h00, 8'h00, 2'd0, 3'd2});
    end
    n_chk++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    int nt = 0;
    int last_tick = 0;
    drive_reset();
    for (int c = 1; c <= 400 && nt < 25; c++) begin
      cycle();
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL free_run cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
      if (m_tick) begin
        nt++;
        n_chk++;
        if (c - last_tick !== 8) begin
          n_err++; $display("FAIL free_run_spacing tick=%0d got=%0d exp=8", nt, c - last_tick);
        end
        last_tick = c;
        if (nt <= 6) begin
          n_chk++;
          if ({ledg, ledr} !== {((nt % 2) == 1) ? 8'hFF : 8'h00, 8'h00}) begin
            n_err++; $display("FAIL mode0_tick%0d got=%h", nt, {ledg, ledr});
          end
        end else if (nt == 7) begin
          n_chk++;
          if ({mode, ledg, ledr} !== {2'd1, 8'h00, 8'hFF}) begin
            n_err++; $display("FAIL mode1_tick7 got=%h exp=%h", {mode, ledg, ledr}, {2'd1, 8'h00, 8'hFF});
          end
        end else if (nt == 13) begin
          n_chk++;
          if ({mode, ledg, ledr} !== {2'd2, 8'hFF, 8'hFF}) begin
            n_err++; $display("FAIL mode2_tick13 got=%h exp=%h", {mode, ledg, ledr}, {2'd2, 8'hFF, 8'hFF});
          end
`ifdef LED_CHASE_EN
        end else if (nt >= 19 && nt <= 24) begin
          n_chk++;
          if ({mode, ledg, ledr} !== {2'd3, 8'(1 << (nt - 19)), 8'h00}) begin
            n_err++; $display("FAIL chase_tick%0d got=%h exp=%h", nt, {mode, ledg, ledr}, {2'd3, 8'(1 << (nt - 19)), 8'h00});
          end
        end else if (nt == 25) begin
`else
        end else if (nt == 19) begin
`endif
          n_chk++;
          if ({mode, ledg} !== {2'd0, 8'hFF}) begin
            n_err++; $display("FAIL wrap_tick%0d got=%h exp=%h", nt, {mode, ledg}, {2'd0, 8'hFF});
          end
        end
      end
    end
    n_chk++;
    if (nt < 25) begin
      n_err++; $display("FAIL free_run_timeout ticks got=%0d exp=25", nt);
    end
  endtask

  task automatic test_slower();
    int c;
    drive_reset();
    press(0, 10);
    wait_tick(c);
    wait_tick(c);
    n_chk++;
    if (c !== 12 || steps !== 3'd3) begin
      n_err++; $display("FAIL slower_once spacing=%0d steps=%0d exp 12/3", c, steps);
    end
    repeat (3) press(0, 6);
    wait_tick(c);
    wait_tick(c);
    n_chk++;
    if (c !== 16 || steps !== 3'd4) begin
      n_err++; $display("FAIL slower_saturate spacing=%0d steps=%0d exp 16/4", c, steps);
    end
    n_chk++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL slower_model got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_faster_default();
    int c;
    drive_reset();
    repeat (3) press(1, 6);
    wait_tick(c);
    wait_tick(c);
    n_chk++;
    if (c !== 4 || steps !== 3'd1) begin
      n_err++; $display("FAIL faster_saturate spacing=%0d steps=%0d exp 4/1", c, steps);
    end
    press(2, 6);
    wait_tick(c);
    wait_tick(c);
    n_chk++;
    if (c !== 8 || steps !== 3'd2) begin
      n_err++; $display("FAIL default_restore spacing=%0d steps=%0d exp 8/2", c, steps);
    end
  endtask

  task automatic test_glitch_and_priority();
    int c;
    drive_reset();
    key[0] = 1'b0;
    repeat (2) cycle();
    key[0] = 1'b1;
    repeat (30) cycle();
    n_chk++;
    if (steps !== 3'd2 || m_pend != 0) begin
      n_err++; $display("FAIL glitch_ignored steps=%0d exp 2", steps);
    end
    key = 3'b100;
    repeat (8) cycle();
    key = 3'b111;
    wait_tick(c);
    wait_tick(c);
    n_chk++;
    if (steps !== 3'd3) begin
      n_err++; $display("FAIL same_cycle_priority steps=%0d exp 3", steps);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    drive_reset();
    for (int i = 0; i < 200 && m_nticks < 13; i++) cycle();
    key[0] = 1'b0;
    for (int i = 0; i < 20 && m_pend == 0; i++) cycle();
    n_chk++;
    if (mode !== 2'd2 || m_pend == 0) begin
      n_err++; $display("FAIL reset_mid_setup mode=%0d pend=%0d exp mode 2 with request", mode, m_pend);
    end
    key[0] = 1'b1;
    rst = 1'b1;
    cycle();
    n_chk++;
    if (dut_vec() !== {8'h00, 8'h00, 2'd0, 3'd2}) begin
      n_err++; $display("FAIL reset_mid_values got=%h exp=%h", dut_vec(), {8'h00, 8'h00, 2'd0, 3'd2});
    end
    rst = 1'b0;
    wait_tick(c);
    n_chk++;
    if (c !== 8 || ledg !== 8'hFF) begin
      n_err++; $display("FAIL reset_mid_first_tick spacing=%0d ledg=%h exp 8/FF", c, ledg);
    end
    wait_tick(c);
    n_chk++;
    if (steps !== 3'd2 || c !== 8) begin
      n_err++; $display("FAIL reset_mid_pending_cleared steps=%0d spacing=%0d exp 2/8", steps, c);
    end
  endtask

  task automatic test_random();
    drive_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 9) == 0) key[k] = ~key[k];
      rst = ($urandom_range(0, 799) == 0);
      cycle();
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
    rst = 1'b0;
    key = 3'b111;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_slower();
    test_faster_default();
    test_glitch_and_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
